// File: rtl/tag_maint_if.sv
// Request, completion and tag-bank port bundle for tag_maint_ctrl.
// The slave side is the controller; the master side is its environment and bank.
interface tag_maint_if #(
  parameter int LINES = 512,
  parameter int TAG_W = 20
);
  localparam int LW = $clog2(LINES);

  logic             fill_valid;
  logic             fill_ready;
  logic [LW-1:0]    fill_line;
  logic [TAG_W-1:0] fill_tag;

  logic             inv_valid;
  logic             inv_ready;
  logic [LW-1:0]    inv_line;
  logic [TAG_W-1:0] inv_tag;
  logic             inv_done;
  logic             inv_hit;

  logic             flush_req;
  logic             flush_done;
  logic             init_done;

  logic             bank_en;
  logic             bank_wen;
  logic [LW-1:0]    bank_addr;
  logic [TAG_W:0]   bank_data_in;
  logic [TAG_W:0]   bank_data_out;

  modport master (
    output fill_valid, fill_line, fill_tag,
    output inv_valid, inv_line, inv_tag,
    output flush_req, bank_data_out,
    input  fill_ready, inv_ready, inv_done, inv_hit,
    input  flush_done, init_done,
    input  bank_en, bank_wen, bank_addr, bank_data_in
  );

  modport slave (
    input  fill_valid, fill_line, fill_tag,
    input  inv_valid, inv_line, inv_tag,
    input  flush_req, bank_data_out,
    output fill_ready, inv_ready, inv_done, inv_hit,
    output flush_done, init_done,
    output bank_en, bank_wen, bank_addr, bank_data_in
  );
endinterface

// File: rtl/tag_maint_ctrl.sv
// Tag-bank maintenance controller: reset/flush sweep, zero-latency line fills,
// and fixed-latency read-compare-clear invalidates on a single bank port.
module tag_maint_ctrl #(
  parameter int LINES = 512,
  parameter int TAG_W = 20
) (
  input  logic        clk,
  input  logic        rst,
  tag_maint_if.slave  io_bus
);
  localparam int LW = $clog2(LINES);
  localparam logic [LW-1:0] LAST_LINE = LW'(LINES - 1);

  typedef enum logic [1:0] {
    SWEEP   = 2'd0,
    IDLE    = 2'd1,
    INV_RD  = 2'd2,
    INV_CMP = 2'd3
  } state_t;

  state_t           r_state, w_next;
  logic [LW-1:0]    r_cnt, w_cnt_nxt;
  logic [LW-1:0]    r_inv_line;
  logic [TAG_W-1:0] r_inv_tag;
  logic             r_flush_sweep;
  logic             r_init_done;

  logic             w_inv_acc, w_flush_acc, w_sweep_end, w_hit;
  logic             w_en, w_wen, w_fill_rdy, w_inv_rdy, w_done, w_hit_o, w_fdone;
  logic [LW-1:0]    w_addr;
  logic [TAG_W:0]   w_wdata;

  // Next-state and bank-port decode
  always_comb begin
    w_next      = r_state;
    w_cnt_nxt   = r_cnt;
    w_inv_acc   = 1'b0;
    w_flush_acc = 1'b0;
    w_sweep_end = 1'b0;
    w_en        = 1'b0;
    w_wen       = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;
    w_fill_rdy  = 1'b0;
    w_inv_rdy   = 1'b0;
    w_done      = 1'b0;
    w_hit_o     = 1'b0;
    w_fdone     = 1'b0;
    w_hit       = io_bus.bank_data_out[TAG_W] &&
                  (io_bus.bank_data_out[TAG_W-1:0] == r_inv_tag);
    case (r_state)
      SWEEP: begin
        w_en   = 1'b1;
        w_wen  = 1'b1;
        w_addr = r_cnt;
        if (r_cnt == LAST_LINE) begin
          w_sweep_end = 1'b1;
          w_fdone     = r_flush_sweep;
          w_cnt_nxt   = '0;
          w_next      = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + LW'(1);
        end
      end
      IDLE: begin
        w_fill_rdy = ~io_bus.flush_req;
        w_inv_rdy  = ~io_bus.flush_req;
        if (io_bus.flush_req) begin
          w_flush_acc = 1'b1;
          w_cnt_nxt   = '0;
          w_next      = SWEEP;
        end else if (io_bus.inv_valid) begin
          w_inv_acc = 1'b1;
          w_next    = INV_RD;
        end else if (io_bus.fill_valid) begin
          w_en    = 1'b1;
          w_wen   = 1'b1;
          w_addr  = io_bus.fill_line;
          w_wdata = {1'b1, io_bus.fill_tag};
        end else begin
          w_next = IDLE;
        end
      end
      INV_RD: begin
        w_en   = 1'b1;
        w_addr = r_inv_line;
        w_next = INV_CMP;
      end
      INV_CMP: begin
        w_done  = 1'b1;
        w_hit_o = w_hit;
        w_addr  = r_inv_line;
        if (w_hit) begin
          w_en  = 1'b1;
          w_wen = 1'b1;
        end else begin
          w_en  = 1'b0;
        end
        w_next = IDLE;
      end
      default: begin
        w_next    = SWEEP;
        w_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs forced low while reset is held, so an aborted operation never shows
  always_comb begin
    if (rst) begin
      io_bus.bank_en      = 1'b0;
      io_bus.bank_wen     = 1'b0;
      io_bus.bank_addr    = '0;
      io_bus.bank_data_in = '0;
      io_bus.fill_ready   = 1'b0;
      io_bus.inv_ready    = 1'b0;
      io_bus.inv_done     = 1'b0;
      io_bus.inv_hit      = 1'b0;
      io_bus.flush_done   = 1'b0;
      io_bus.init_done    = 1'b0;
    end else begin
      io_bus.bank_en      = w_en;
      io_bus.bank_wen     = w_wen;
      io_bus.bank_addr    = w_addr;
      io_bus.bank_data_in = w_wdata;
      io_bus.fill_ready   = w_fill_rdy;
      io_bus.inv_ready    = w_inv_rdy;
      io_bus.inv_done     = w_done;
      io_bus.inv_hit      = w_hit_o;
      io_bus.flush_done   = w_fdone;
      io_bus.init_done    = r_init_done | w_sweep_end;
    end
  end

  // State, sweep counter and captured invalidate request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= SWEEP;
      r_cnt         <= '0;
      r_inv_line    <= '0;
      r_inv_tag     <= '0;
      r_flush_sweep <= 1'b0;
      r_init_done   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_flush_acc) begin
        r_flush_sweep <= 1'b1;
      end else if (w_sweep_end) begin
        r_flush_sweep <= 1'b0;
      end
      if (w_sweep_end) begin
        r_init_done <= 1'b1;
      end
      if (w_inv_acc) begin
        r_inv_line <= io_bus.inv_line;
        r_inv_tag  <= io_bus.inv_tag;
      end
    end
  end
endmodule
